// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the registered N-channel round-robin mux.
package rr_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_t;

    // Next channel index after idx, wrapping from n-1 back to 0.
    function automatic int nextIdx(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping around.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            en,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_vld
);

    int              scanIdx;
    logic [SELW-1:0] scanSel;

    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        scanIdx = 0;
        scanSel = '0;
        if (en) begin
            for (int off = 0; off < N; off++) begin
                scanIdx = int'(ptr) + off;
                if (scanIdx >= N) begin
                    scanIdx = scanIdx - N;
                end
                scanSel = SELW'(scanIdx);
                if (!gnt_vld && req[scanSel]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = scanSel;
                end
            end
        end
    end

endmodule

// File: rtl/rr_mux_reg.sv
// N-channel WIDTH-bit mux with fixed or round-robin selection, valid/ready
// handshakes on every channel and a one-entry registered output.
module rr_mux_reg
    import rr_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] outData_q, outData_d;
    logic [SELW-1:0]  outCh_q, outCh_d;
    logic             outValid_q, outValid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    mux_mode_t        modeSel;
    logic             load;
    logic             fixedVld;
    logic [SELW-1:0]  rrIdx;
    logic             rrVld;
    logic [SELW-1:0]  gntIdx;
    logic             gntVld;

    assign modeSel = mux_mode_t'(mode);

    // Held in reset, nothing may be acknowledged, so load is gated by rst_n.
    assign load = rst_n && (!outValid_q || out_ready);

    always_comb begin
        fixedVld = 1'b0;
        if (load && (int'(sel) < N)) begin
            fixedVld = in_valid[sel];
        end
    end

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arbiter (
        .req     (in_valid),
        .ptr     (ptr_q),
        .en      (load && (modeSel == MODE_RR)),
        .gnt_idx (rrIdx),
        .gnt_vld (rrVld)
    );

    always_comb begin
        gntIdx = sel;
        gntVld = fixedVld;
        if (modeSel == MODE_RR) begin
            gntIdx = rrIdx;
            gntVld = rrVld;
        end
    end

    always_comb begin
        in_ready = '0;
        if (gntVld) begin
            in_ready[gntIdx] = 1'b1;
        end
    end

    // Only the granted slice is read, so X on idle channels never reaches the register.
    always_comb begin
        outData_d  = outData_q;
        outCh_d    = outCh_q;
        outValid_d = outValid_q;
        ptr_d      = ptr_q;
        if (load) begin
            outValid_d = gntVld;
            if (gntVld) begin
                outData_d = in_data[int'(gntIdx) * WIDTH +: WIDTH];
                outCh_d   = gntIdx;
                if (modeSel == MODE_RR) begin
                    ptr_d = SELW'(nextIdx(int'(gntIdx), N));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outData_q  <= '0;
            outCh_q    <= '0;
            outValid_q <= 1'b0;
            ptr_q      <= '0;
        end else begin
            outData_q  <= outData_d;
            outCh_q    <= outCh_d;
            outValid_q <= outValid_d;
            ptr_q      <= ptr_d;
        end
    end

    assign out_data  = outData_q;
    assign out_ch    = outCh_q;
    assign out_valid = outValid_q;

endmodule
